// File: rtl/seq_mult_ctrl.sv
// Control FSM for a shift-and-add sequential multiplier.
// Sequences load, DW add/shift iterations (optionally cut short once the multiplier empties) and a held result handshake.
module seq_mult_ctrl #(
  parameter  int DW         = 4,
  parameter  bit EARLY_EXIT = 1'b1,
  localparam int CW         = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mplr_lsb,
  input  logic          mplr_zero,
  input  logic          ack,
  output logic          ready,
  output logic          load_en,
  output logic          add_en,
  output logic          shift_en,
  output logic          done,
  output logic          busy,
  output logic [CW-1:0] count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] count_nxt;
  logic          early_exit;

  assign early_exit = EARLY_EXIT && mplr_zero;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    add_en    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
          count_nxt = '0;
        end
      end
      S_LOAD: begin
        state_nxt = S_CALC;
        count_nxt = '0;
      end
      S_CALC: begin
        // An empty multiplier has nothing left to add, so finish without touching the datapath.
        if (early_exit) begin
          state_nxt = S_DONE;
        end else begin
          shift_en  = 1'b1;
          add_en    = mplr_lsb;
          count_nxt = count + 1'b1;
          if (count == LAST_ITER) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (ack) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Moore outputs: reset reaches them through state with no clock needed.
  assign ready   = (state == S_IDLE);
  assign load_en = (state == S_LOAD);
  assign done    = (state == S_DONE);
  assign busy    = (state == S_LOAD) || (state == S_CALC);

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 4, operand width in bits (DW >= 2).
REQ-002 The block SHALL have parameter EARLY_EXIT, default 1, which enables early termination when the multiplier register is zero.
REQ-003 The block SHALL have localparam CW = $clog2(DW)+1, the iteration counter width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  multiply request; sampled only while ready=1.
REQ-007 mplr_lsb  input  1  current LSB of the datapath multiplier shift register.
REQ-008 mplr_zero  input  1  high when the datapath multiplier register is all-zero.
REQ-009 ack  input  1  consumer acceptance of the result; sampled only while done=1.
REQ-010 ready  output  1  controller idle and accepting start.
REQ-011 load_en  output  1  load the operand registers and clear the product register.
REQ-012 add_en  output  1  product register enable (accumulate the shifted multiplicand).
REQ-013 shift_en  output  1  shift the multiplicand left and the multiplier right by one.
REQ-014 done  output  1  product valid; held until acknowledged.
REQ-015 busy  output  1  high in LOAD or CALC.
REQ-016 count  output  CW  number of CALC iterations completed.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, CALC, DONE; encoding is free.
REQ-018 IDLE behaviour:
- ready=1; all other control outputs are 0.
- start=1 moves to LOAD on the next edge; otherwise the FSM stays in IDLE.
REQ-019 LOAD behaviour:
- load_en=1 for exactly one cycle.
- count is cleared to 0.
- The FSM moves unconditionally to CALC.
REQ-020 CALC, non-exit cycle:
- shift_en=1 and add_en=mplr_lsb, both combinational in the same cycle.
- count increments by 1.
REQ-021 CALC exit: the FSM SHALL leave CALC for DONE after the cycle in which count==DW-1 (DW iterations in total).
REQ-022 CALC early exit: when EARLY_EXIT=1 and mplr_zero=1 in a CALC cycle:
- add_en=0 and shift_en=0 in that cycle.
- count holds.
- The FSM moves to DONE.
- This takes priority over REQ-020.
REQ-023 When EARLY_EXIT=0, mplr_zero SHALL be ignored.
REQ-024 DONE behaviour:
- done=1 and count holds.
- ack=1 moves to IDLE on the next edge; otherwise the FSM stays in DONE indefinitely.
REQ-025 Ignored inputs:
- start outside IDLE is ignored, including start coincident with ack in DONE.
- ack outside DONE is ignored.
- A start must be re-presented once ready=1.
REQ-026 Latency: with start accepted at edge 0 and no early exit:
- load_en is high in cycle 1.
- CALC occupies cycles 2..DW+1.
- done rises in cycle DW+2.
REQ-027 Output decoding:
- ready, load_en, done and busy SHALL be decoded from state only (Moore).
- add_en and shift_en SHALL depend only on state, mplr_lsb and mplr_zero.
REQ-028 count SHALL never exceed DW and SHALL NOT wrap.

Reset
REQ-029 rst=0 SHALL asynchronously force the following, regardless of clk or the current state (including mid-CALC):
- State IDLE, count=0.
- load_en=add_en=shift_en=done=busy=0.
- ready=1.
REQ-030 After rst deasserts, the first start SHALL be accepted normally on the next edge.

Verification
REQ-031 Reset mid-CALC (DW=4): assert rst=0 between edges -> ready=1, busy=0, count=0 and add_en/shift_en=0 immediately, with no clock edge.
REQ-032 Full run: DW=4, EARLY_EXIT=0, multiplier 4'b1011 -> load_en in cycle 1; add_en 1,1,0,1 in cycles 2-5; shift_en 1 in cycles 2-5; done=1 from cycle 6, count=4.
REQ-033 Early exit: EARLY_EXIT=1, multiplier 4'b0011 -> add_en 1,1 in cycles 2-3; cycle 4 has mplr_zero=1 with add_en=shift_en=0; done in cycle 5, count=2.
REQ-034 Zero operand: EARLY_EXIT=1, multiplier 0 -> add_en never asserts; done in cycle 3, count=0.
REQ-035 Back-pressure: hold ack=0 for 10 cycles in DONE and pulse start -> done stays 1, start ignored, ready=0; then ack=1 -> ready=1 on the next cycle, done=0.
REQ-036 Stray inputs: pulse ack during CALC and start during CALC/LOAD -> no change in state sequence or count; the result completes as in REQ-032.
